fetch_pc_unit: RTL and testbench



---
 rtl/fetch_pc_unit.sv | 98 +++++++++
 tb/tb_fetch_pc_unit.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency instruction
// memory, squashes wrong-path fetches on redirect and absorbs decode stalls.
module fetch_pc_unit #(
  parameter int                     PC_WIDTH    = 16,
  parameter int                     INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   jump,
  input  logic [PC_WIDTH-1:0]    jump_target,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [PC_WIDTH-1:0]    if_pc,
  output logic [PC_WIDTH-1:0]    if_pc_plus1,
  output logic                   if_valid,
  output logic                   id_flush
);

  typedef enum logic [1:0] {BOOT, RUN, HELD} state_e;

  state_e                 state_q;
  logic [PC_WIDTH-1:0]    pc_q;
  logic [PC_WIDTH-1:0]    req_pc_q;
  logic                   req_valid_q;
  logic [INSTR_WIDTH-1:0] hold_q;

  logic                   redirect;
  logic [PC_WIDTH-1:0]    target;

  // Branch wins over jump: it belongs to the older instruction.
  assign redirect = branch_taken | jump;
  assign target   = branch_taken ? branch_target : jump_target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      req_pc_q    <= '0;
      req_valid_q <= 1'b0;
      hold_q      <= '0;
    end else if (redirect) begin
      pc_q        <= target;
      req_valid_q <= 1'b0;
      state_q     <= RUN;
    end else begin
      case (state_q)
        BOOT: begin
          pc_q        <= pc_q + PC_WIDTH'(1);
          req_pc_q    <= pc_q;
          req_valid_q <= 1'b1;
          state_q     <= RUN;
        end
        RUN: begin
          if (stall) begin
            hold_q  <= imem_rdata;
            state_q <= HELD;
          end else begin
            pc_q        <= pc_q + PC_WIDTH'(1);
            req_pc_q    <= pc_q;
            req_valid_q <= 1'b1;
          end
        end
        HELD: begin
          // pc was frozen, so memory already re-reads the successor word.
          if (!stall) begin
            pc_q        <= pc_q + PC_WIDTH'(1);
            req_pc_q    <= pc_q;
            req_valid_q <= 1'b1;
            state_q     <= RUN;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

  always_comb begin
    if_instr = imem_rdata;
    if_valid = req_valid_q;
    if (state_q == BOOT) begin
      if_instr = '0;
      if_valid = 1'b0;
    end else if (state_q == HELD) begin
      if_instr = hold_q;
    end
  end

  assign imem_addr   = pc_q;
  assign if_pc       = req_pc_q;
  assign if_pc_plus1 = req_pc_q + PC_WIDTH'(1);
  assign id_flush    = branch_taken;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: stream-level model checked every cycle plus
// directed literal checks along the scenario.
module tb_fetch_pc_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch_taken, jump;
  logic [15:0] branch_target, jump_target;
  logic [15:0] imem_addr, imem_rdata;
  logic [15:0] if_instr, if_pc, if_pc_plus1;
  logic        if_valid, id_flush;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_pc_unit #(.PC_WIDTH(16), .INSTR_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_instr(if_instr), .if_pc(if_pc), .if_pc_plus1(if_pc_plus1),
    .if_valid(if_valid), .id_flush(id_flush)
  );

  always #5 clk = ~clk;

  // Synchronous memory, one cycle of latency, contents addr ^ A000.
  always @(posedge clk) imem_rdata <= imem_addr ^ 16'hA000;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stream model: m_pc is the next address to fetch, m_out the instruction
  // currently offered to decode (meaningful when m_valid).
  logic [15:0] m_pc    = 16'h0000;
  logic [15:0] m_out   = 16'h0000;
  logic        m_valid = 1'b0;
  logic        m_boot  = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 16'h0000; m_out = 16'h0000; m_valid = 1'b0; m_boot = 1'b1;
    end else if (branch_taken || jump) begin
      m_boot  = 1'b0;
      m_valid = 1'b0;
      m_pc    = branch_taken ? branch_target : jump_target;
    end else if (m_boot || !stall) begin
      m_boot  = 1'b0;
      m_valid = 1'b1;
      m_out   = m_pc;
      m_pc    = m_pc + 16'd1;
    end
  end

  always @(negedge clk) begin
    chk("m_addr", {16'h0, imem_addr}, {16'h0, m_pc});
    chk("m_valid", {31'h0, if_valid}, {31'h0, m_valid});
    chk("m_flush", {31'h0, id_flush}, {31'h0, branch_taken});
    if (m_valid) begin
      chk("m_pc", {16'h0, if_pc}, {16'h0, m_out});
      chk("m_instr", {16'h0, if_instr}, {16'h0, m_out ^ 16'hA000});
      chk("m_plus1", {16'h0, if_pc_plus1}, {16'h0, m_out + 16'd1});
    end
    if (!rst_n) begin
      chk("m_rst_instr", {16'h0, if_instr}, 32'h0);
      chk("m_rst_pc", {16'h0, if_pc}, 32'h0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic out_is(input string nm, input logic [15:0] pc, input logic [15:0] ins);
    chk({nm, "_valid"}, {31'h0, if_valid}, 32'h1);
    chk({nm, "_pc"}, {16'h0, if_pc}, {16'h0, pc});
    chk({nm, "_instr"}, {16'h0, if_instr}, {16'h0, ins});
  endtask

  task automatic reset_vals(input string nm);
    chk({nm, "_valid"}, {31'h0, if_valid}, 32'h0);
    chk({nm, "_instr"}, {16'h0, if_instr}, 32'h0);
    chk({nm, "_pc"}, {16'h0, if_pc}, 32'h0);
    chk({nm, "_addr"}, {16'h0, imem_addr}, 32'h0);
  endtask

  initial begin
    rst_n = 1'b1; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    branch_target = 16'h0; jump_target = 16'h0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_vals("rst");
    rst_n = 1'b1;
    chk("boot_valid", {31'h0, if_valid}, 32'h0);
    step(); out_is("run0", 16'h0000, 16'hA000);
    step(); out_is("run1", 16'h0001, 16'hA001);
    step(); out_is("run2", 16'h0002, 16'hA002);
    step(); step(); step();
    out_is("pre_stall", 16'h0005, 16'hA005);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); out_is("stall", 16'h0005, 16'hA005);
    end
    stall = 1'b0;
    step(); out_is("unstall", 16'h0006, 16'hA006);
    step(); out_is("pre_br", 16'h0007, 16'hA007);

    branch_taken = 1'b1; branch_target = 16'h0040;
    #1 chk("br_flush", {31'h0, id_flush}, 32'h1);
    step(); branch_taken = 1'b0;
    chk("br_bubble", {31'h0, if_valid}, 32'h0);
    step(); out_is("br_tgt", 16'h0040, 16'hA040);

    stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0010;
    jump = 1'b1; jump_target = 16'h0020;
    #1 chk("both_flush", {31'h0, id_flush}, 32'h1);
    step(); stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
    chk("both_bubble", {31'h0, if_valid}, 32'h0);
    chk("both_addr", {16'h0, imem_addr}, 32'h0010);
    step(); out_is("both_tgt", 16'h0010, 16'hA010);

    jump = 1'b1; jump_target = 16'hFFFF;
    #1 chk("jmp_noflush", {31'h0, id_flush}, 32'h0);
    step(); jump = 1'b0;
    chk("jmp_bubble", {31'h0, if_valid}, 32'h0);
    step(); out_is("wrap_hi", 16'hFFFF, 16'h5FFF);
    chk("wrap_plus1", {16'h0, if_pc_plus1}, 32'h0000);
    step(); out_is("wrap_lo", 16'h0000, 16'hA000);
    chk("wrap_lo_plus1", {16'h0, if_pc_plus1}, 32'h0001);

    // Redirect to the address already being fetched.
    jump = 1'b1; jump_target = imem_addr;
    step(); jump = 1'b0;
    chk("self_bubble", {31'h0, if_valid}, 32'h0);
    step(); out_is("self_tgt", 16'h0001, 16'hA001);

    stall = 1'b1;
    step(); step(); out_is("held", 16'h0001, 16'hA001);
    #3 rst_n = 1'b0;
    #1 reset_vals("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("reboot_valid", {31'h0, if_valid}, 32'h0);
    step(); out_is("reboot0", 16'h0000, 16'hA000);
    step(); out_is("reboot_hold", 16'h0000, 16'hA000);
    stall = 1'b0;
    step(); out_is("reboot1", 16'h0001, 16'hA001);
    step(); out_is("reboot2", 16'h0002, 16'hA002);
    @(negedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
